bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter (shift-and-add-3 / double dabble) that sits directly upstream of the seven-segment display controller. It accepts an unsigned binary value on a start/busy/done handshake and produces a registered packed-BCD word, a per-digit leading-zero blank mask and an overflow flag. It converts one bit per clock, trading latency for area. Its outputs stay stable between conversions so the display controller can scan them at any time.

---
 rtl/bin2bcd_seq.sv | 175 +++++++++++++++++
 tb/tb_bin2bcd_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
//   It converts one input bit per clock. Results are registered and held
//   between conversions, so a downstream display scanner can read them at
//   any time.
//
// Parameters
//   WIDTH    binary input width (4..17)
//   DIGITS   number of BCD digits produced (1..5)
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   start     conversion request, sampled only while idle
//   bin       unsigned binary value, captured when start is accepted
//   busy      high while bits are being shifted
//   done      one-cycle pulse; bcd/blank/overflow update in this cycle
//   bcd       packed BCD result, digit 0 in bits [3:0]
//   blank     leading-zero mask per digit; bit 0 is always 0
//   overflow  captured value exceeded 10^DIGITS-1; bcd saturates to all 9s
module bin2bcd_seq #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank,
    output logic                  overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    function automatic int unsigned pow10_m1(input int n);
        int unsigned p;
        p = 32'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 32'd10;
        end
        return p - 32'd1;
    endfunction

    localparam int unsigned       MAX_VAL   = pow10_m1(DIGITS);
    localparam logic [CW-1:0]     CNT_LOAD  = CW'(WIDTH);
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Add 3 to every digit that is 5 or more, so the following doubling
    // carries correctly into the next decimal digit.
    function automatic logic [4*DIGITS-1:0] add3_all(input logic [4*DIGITS-1:0] v);
        logic [4*DIGITS-1:0] r;
        r = v;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[4*d +: 4] >= 4'd5) begin
                r[4*d +: 4] = v[4*d +: 4] + 4'd3;
            end else begin
                r[4*d +: 4] = v[4*d +: 4];
            end
        end
        return r;
    endfunction

    // A digit is blanked when it and every more significant digit are zero;
    // the units digit always shows, and nothing is blanked on saturation.
    function automatic logic [DIGITS-1:0] blank_of(input logic [4*DIGITS-1:0] v,
                                                   input logic ovf);
        logic [DIGITS-1:0] m;
        logic              z;
        m = {DIGITS{1'b0}};
        z = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            z    = z & (v[4*i +: 4] == 4'd0);
            m[i] = z;
        end
        if (ovf) begin
            m = {DIGITS{1'b0}};
        end
        return m;
    endfunction

    state_t              state_r, state_s;
    logic [WIDTH-1:0]    shreg_r;
    logic [4*DIGITS-1:0] scratch_r;
    logic [CW-1:0]       cnt_r;
    logic                ovf_r;
    logic                ovf_s;
    logic [4*DIGITS-1:0] adj_s;
    logic [4*DIGITS-1:0] scratch_s;
    logic [4*DIGITS-1:0] bcd_load_s;

    // Datapath helpers: range check on the raw input, adjust-and-shift step,
    // and the value that will be presented when the conversion finishes.
    always_comb begin
        ovf_s      = 32'(bin) > MAX_VAL;
        adj_s      = add3_all(scratch_r);
        scratch_s  = (adj_s << 1) | (4*DIGITS)'(shreg_r[WIDTH-1]);
        bcd_load_s = ovf_r ? {DIGITS{4'h9}} : scratch_s;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == CW'(1)) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            shreg_r   <= {WIDTH{1'b0}};
            scratch_r <= {4*DIGITS{1'b0}};
            cnt_r     <= {CW{1'b0}};
            ovf_r     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd       <= {4*DIGITS{1'b0}};
            blank     <= BLANK_RST;
            overflow  <= 1'b0;
        end else begin
            state_r <= state_s;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        shreg_r   <= bin;
                        scratch_r <= {4*DIGITS{1'b0}};
                        cnt_r     <= CNT_LOAD;
                        ovf_r     <= ovf_s;
                    end
                end
                SHIFT: begin
                    scratch_r <= scratch_s;
                    shreg_r   <= shreg_r << 1;
                    cnt_r     <= cnt_r - CW'(1);
                end
                default: begin
                end
            endcase
            // Results only change on the final shift into DONE.
            if ((state_r == SHIFT) && (state_s == DONE)) begin
                bcd      <= bcd_load_s;
                blank    <= blank_of(bcd_load_s, ovf_r);
                overflow <= ovf_r;
            end
            busy <= (state_s == SHIFT);
            done <= (state_s == DONE);
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [13:0] bin;
    logic        busy, done, overflow;
    logic [15:0] bcd;
    logic [3:0]  blank;

    logic        start2;
    logic [6:0]  bin2;
    logic        busy2, done2, overflow2;
    logic [7:0]  bcd2;
    logic [1:0]  blank2;

    int checks = 0;
    int errors = 0;

    bin2bcd_seq #(.WIDTH(14), .DIGITS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .busy(busy), .done(done), .bcd(bcd), .blank(blank), .overflow(overflow)
    );

    bin2bcd_seq #(.WIDTH(7), .DIGITS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .bin(bin2),
        .busy(busy2), .done(done2), .bcd(bcd2), .blank(blank2), .overflow(overflow2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] v;
        logic [15:0] b;
        logic [3:0]  bl;
        logic        ov;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [3:0] ref_blank(input int v);
        if (v > 9999) return 4'b0000;
        return {v < 1000, v < 100, v < 10, 1'b0};
    endfunction

    // Waits for done; cyc counts cycles after the acceptance cycle.
    task automatic wait_done(output int cyc, output int nbusy, output int overlap);
        cyc = 0; nbusy = 0; overlap = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) nbusy++;
            @(posedge clk); #1;
            cyc++;
        end
        if (busy === 1'b1 && done === 1'b1) overlap = 1;
    endtask

    task automatic conv(input logic [13:0] v, output int cyc, output int nbusy, output int overlap);
        @(posedge clk); #1;
        start = 1'b1; bin = v;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc, nbusy, overlap);
    endtask

    task automatic conv2(input logic [6:0] v, output int cyc);
        @(posedge clk); #1;
        start2 = 1'b1; bin2 = v;
        @(posedge clk); #1;
        start2 = 1'b0;
        cyc = 0;
        while (done2 !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        int cyc, nb, ov, v, bad, npulse, last_t, t, saw;

        vecs[0] = '{14'd1234,  16'h1234, 4'b0000, 1'b0};
        vecs[1] = '{14'd0,     16'h0000, 4'b1110, 1'b0};
        vecs[2] = '{14'd42,    16'h0042, 4'b1100, 1'b0};
        vecs[3] = '{14'd9999,  16'h9999, 4'b0000, 1'b0};
        vecs[4] = '{14'd10000, 16'h9999, 4'b0000, 1'b1};
        vecs[5] = '{14'd16383, 16'h9999, 4'b0000, 1'b1};
        vecs[6] = '{14'd7,     16'h0007, 4'b1110, 1'b0};
        vecs[7] = '{14'd100,   16'h0100, 4'b1000, 1'b0};

        rst = 1'b1; start = 1'b0; bin = 14'd0; start2 = 1'b0; bin2 = 7'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_bcd", 32'(bcd), 32'h0);
        chk("reset_blank", 32'(blank), 32'b1110);
        chk("reset_ovf", 32'(overflow), 32'd0);

        // Table of directed conversions
        for (int i = 0; i < 8; i++) begin
            conv(vecs[i].v, cyc, nb, ov);
            chk($sformatf("lat_%0d", vecs[i].v), 32'(cyc), 32'd14);
            chk($sformatf("busy_cycles_%0d", vecs[i].v), 32'(nb), 32'd14);
            chk($sformatf("busy_done_overlap_%0d", vecs[i].v), 32'(ov), 32'd0);
            chk($sformatf("bcd_%0d", vecs[i].v), 32'(bcd), 32'(vecs[i].b));
            chk($sformatf("blank_%0d", vecs[i].v), 32'(blank), 32'(vecs[i].bl));
            chk($sformatf("ovf_%0d", vecs[i].v), 32'(overflow), 32'(vecs[i].ov));
            @(posedge clk); #1;
            chk($sformatf("done_pulse_%0d", vecs[i].v), 32'(done), 32'd0);
            chk($sformatf("hold_%0d", vecs[i].v), 32'(bcd), 32'(vecs[i].b));
        end

        // Start while busy is dropped
        @(posedge clk); #1;
        start = 1'b1; bin = 14'd1234;
        @(posedge clk); #1;          // cycle 1
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;                          // cycle 5
        start = 1'b1; bin = 14'd5678;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc, nb, ov);
        chk("drop_timeout", 32'(done), 32'd1);
        chk("drop_bcd", 32'(bcd), 32'h1234);
        saw = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (busy === 1'b1 || done === 1'b1) saw = 1;
        end
        chk("drop_no_second", 32'(saw), 32'd0);

        // Back-to-back with start held high
        @(posedge clk); #1;
        start = 1'b1; bin = 14'd5678;
        npulse = 0; last_t = 0; bad = 0; t = 0;
        while (npulse < 3 && t < 100) begin
            @(posedge clk); #1;
            t++;
            if (busy === 1'b1 && done === 1'b1) bad = 1;
            if (done === 1'b1) begin
                chk("b2b_bcd", 32'(bcd), 32'h5678);
                if (npulse > 0) chk("b2b_spacing", 32'(t - last_t), 32'd16);
                npulse++;
                last_t = t;
                if (npulse == 3) start = 1'b0;
            end else if (npulse > 0 && bcd !== 16'h5678) begin
                bad = 1;
            end
        end
        chk("b2b_pulses", 32'(npulse), 32'd3);
        chk("b2b_stable", 32'(bad), 32'd0);
        repeat (3) @(posedge clk);

        // Reset in the middle of a conversion
        @(posedge clk); #1;
        start = 1'b1; bin = 14'd9876;
        @(posedge clk); #1;          // cycle 1
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;                          // cycle 7
        rst = 1'b1; start = 1'b1; bin = 14'd4321;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_bcd", 32'(bcd), 32'h0);
        chk("abort_blank", 32'(blank), 32'b1110);
        chk("abort_ovf", 32'(overflow), 32'd0);
        saw = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (busy === 1'b1 || done === 1'b1) saw = 1;
        end
        chk("abort_no_done", 32'(saw), 32'd0);
        conv(14'd305, cyc, nb, ov);
        chk("after_abort_lat", 32'(cyc), 32'd14);
        chk("after_abort_bcd", 32'(bcd), 32'h0305);
        chk("after_abort_blank", 32'(blank), 32'b1000);

        // Randomised sweep against the reference model
        for (int i = 0; i < 150; i++) begin
            if (i == 0) v = 9998;
            else if (i == 1) v = 10001;
            else v = int'($urandom_range(0, 16383));
            conv(14'(v), cyc, nb, ov);
            chk($sformatf("rnd_lat_%0d", v), 32'(cyc), 32'd14);
            chk($sformatf("rnd_bcd_%0d", v), 32'(bcd), 32'(ref_bcd(v)));
            chk($sformatf("rnd_blank_%0d", v), 32'(blank), 32'(ref_blank(v)));
            chk($sformatf("rnd_ovf_%0d", v), 32'(overflow), 32'(v > 9999));
        end

        // Two-digit, seven-bit instance
        conv2(7'd99, cyc);
        chk("d2_lat_99", 32'(cyc), 32'd7);
        chk("d2_bcd_99", 32'(bcd2), 32'h99);
        chk("d2_blank_99", 32'(blank2), 32'b00);
        chk("d2_ovf_99", 32'(overflow2), 32'd0);
        conv2(7'd100, cyc);
        chk("d2_bcd_100", 32'(bcd2), 32'h99);
        chk("d2_blank_100", 32'(blank2), 32'b00);
        chk("d2_ovf_100", 32'(overflow2), 32'd1);
        conv2(7'd5, cyc);
        chk("d2_bcd_5", 32'(bcd2), 32'h05);
        chk("d2_blank_5", 32'(blank2), 32'b10);
        chk("d2_ovf_5", 32'(overflow2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
